// File: rtl/periodogram_frame_buffer.sv
// periodogram_frame_buffer: ping-pong store of per-bin power frames,
// replayed over valid/ready with per-frame peak and drop reporting.
module periodogram_frame_buffer #(
  parameter  int NF = 512,
  parameter  int DW = 32,
  localparam int IW = $clog2(NF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] periodogram_in,
  input  logic          periodogram_valid,
  output logic [DW-1:0] bin_out,
  output logic [IW-1:0] bin_index,
  output logic          bin_valid,
  input  logic          bin_ready,
  output logic          bin_last,
  output logic [DW-1:0] frame_peak_value,
  output logic [IW-1:0] frame_peak_index,
  output logic          overflow
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM
  } rd_state_t;

  rd_state_t state;
  rd_state_t state_nxt;

  // Both banks share one array; the bank bit is the address MSB.
  logic [DW-1:0] mem [2*NF];
  logic [DW-1:0] rd_data;
  logic [IW:0]   rd_addr;
  logic [IW-1:0] rd_ptr;
  logic          rd_en;

  logic [IW-1:0] wr_idx;
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic          drop_q;

  logic xfer;
  logic rd_release;
  logic frame_start;
  logic reject;
  logic dropping;
  logic wr_en;
  logic wr_done;

  logic [DW-1:0] pk_val;
  logic [DW-1:0] pk_val_nxt;
  logic [IW-1:0] pk_idx;
  logic [IW-1:0] pk_idx_nxt;
  logic [DW-1:0] bank_pk_val [2];
  logic [IW-1:0] bank_pk_idx [2];

  assign xfer        = bin_valid && bin_ready;
  assign rd_release  = xfer && bin_last;
  assign frame_start = (wr_idx == '0);

  // A bank freed on this very edge can take the new frame.
  assign reject   = full[wr_bank] &&
                    !(rd_release && (rd_bank == wr_bank));
  assign dropping = frame_start ? reject : drop_q;
  assign wr_en    = periodogram_valid && !dropping;
  assign wr_done  = wr_en && (&wr_idx);

  assign bin_valid = (state == STREAM);
  assign bin_last  = bin_valid && (&bin_index);
  assign bin_out   = bin_valid ? rd_data : '0;

  assign frame_peak_value = bank_pk_val[rd_bank];
  assign frame_peak_index = bank_pk_idx[rd_bank];

  // Write framing: bin counter, bank pointer, drop decision at bin 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx   <= '0;
      wr_bank  <= 1'b0;
      drop_q   <= 1'b0;
      overflow <= 1'b0;
    end else if (periodogram_valid) begin
      wr_idx <= wr_idx + 1'b1;
      if (frame_start) begin
        drop_q <= reject;
        if (reject) overflow <= 1'b1;
      end
      if (wr_done) wr_bank <= ~wr_bank;
    end
  end

  // Bank occupancy: set by the writer, cleared by the reader.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
    end else begin
      if (wr_done) full[wr_bank] <= 1'b1;
      if (rd_release) full[rd_bank] <= 1'b0;
    end
  end

  // Running peak candidate; ties keep the earliest bin.
  always_comb begin
    pk_val_nxt = pk_val;
    pk_idx_nxt = pk_idx;
    if (frame_start) begin
      pk_val_nxt = periodogram_in;
      pk_idx_nxt = '0;
    end else if ($signed(periodogram_in) >
                 $signed(pk_val)) begin
      pk_val_nxt = periodogram_in;
      pk_idx_nxt = wr_idx;
    end
  end

  // Peak tracking and per-bank latch at frame completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pk_val <= '0;
      pk_idx <= '0;
      for (int b = 0; b < 2; b++) begin
        bank_pk_val[b] <= '0;
        bank_pk_idx[b] <= '0;
      end
    end else if (wr_en) begin
      pk_val <= pk_val_nxt;
      pk_idx <= pk_idx_nxt;
      if (wr_done) begin
        bank_pk_val[wr_bank] <= pk_val_nxt;
        bank_pk_idx[wr_bank] <= pk_idx_nxt;
      end
    end
  end

  // Read address: bin 0 on fetch, otherwise the bin after the offered one.
  always_comb begin
    rd_ptr = bin_index + 1'b1;
    if (state == FETCH) rd_ptr = '0;
    rd_addr = {rd_bank, rd_ptr};
    rd_en   = (state == FETCH) || xfer;
  end

  // Simple dual-port RAM; read register doubles as the output stage.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_idx}] <= periodogram_in;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Reader FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Reader next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (full[rd_bank]) state_nxt = FETCH;
      FETCH:   state_nxt = STREAM;
      STREAM:  if (rd_release) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output bin index and read bank pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_index <= '0;
      rd_bank   <= 1'b0;
    end else if (state == FETCH) begin
      bin_index <= '0;
    end else if (xfer) begin
      bin_index <= bin_index + 1'b1;
      if (bin_last) rd_bank <= ~rd_bank;
    end
  end

endmodule

// File: tb/tb_periodogram_frame_buffer.sv
// Directed bench for periodogram_frame_buffer at NF=8:
// framing, back-pressure, ping-pong, overflow, peak ties, reset.
module tb_periodogram_frame_buffer;
  localparam int NF  = 8;
  localparam int DW  = 32;
  localparam int IW  = 3;
  localparam int GAP = -1000000;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] periodogram_in;
  logic          periodogram_valid;
  logic [DW-1:0] bin_out;
  logic [IW-1:0] bin_index;
  logic          bin_valid;
  logic          bin_ready;
  logic          bin_last;
  logic [DW-1:0] frame_peak_value;
  logic [IW-1:0] frame_peak_index;
  logic          overflow;

  int checks;
  int fails;
  int wq[$];
  int ev[$];
  int epk[$];
  int epi[$];

  always #5 clk = ~clk;

  periodogram_frame_buffer #(
    .NF(NF),
    .DW(DW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .periodogram_in   (periodogram_in),
    .periodogram_valid(periodogram_valid),
    .bin_out          (bin_out),
    .bin_index        (bin_index),
    .bin_valid        (bin_valid),
    .bin_ready        (bin_ready),
    .bin_last         (bin_last),
    .frame_peak_value (frame_peak_value),
    .frame_peak_index (frame_peak_index),
    .overflow         (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_seq();
    foreach (wq[i]) begin
      periodogram_valid = (wq[i] != GAP);
      periodogram_in = (wq[i] != GAP) ? DW'(wq[i]) : '0;
      tick();
    end
    periodogram_valid = 1'b0;
    periodogram_in = '0;
  endtask

  task automatic read_expect(input string name, input bit toggle);
    int k;
    int cyc;
    int budget;
    bit held;
    logic [DW-1:0] hv;
    logic [IW-1:0] hi;
    logic hl;
    k = 0;
    cyc = 0;
    budget = 400;
    held = 1'b0;
    hv = '0;
    hi = '0;
    hl = 1'b0;
    while (k < ev.size() && budget > 0) begin
      bin_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      cyc++;
      if (held) begin
        checks++;
        if (bin_valid !== 1'b1 || bin_out !== hv ||
            bin_index !== hi || bin_last !== hl) begin
          fails++;
          $display("FAIL %s hold: v=%b out=%0d idx=%0d last=%b, required 1 %0d %0d %b",
                   name, bin_valid, $signed(bin_out), bin_index,
                   bin_last, $signed(hv), hi, hl);
        end
      end
      held = 1'b0;
      if (bin_valid && bin_ready) begin
        checks++;
        if (bin_out !== DW'(ev[k])) begin
          fails++;
          $display("FAIL %s data[%0d]: got %0d, required %0d",
                   name, k, $signed(bin_out), ev[k]);
        end
        checks++;
        if (bin_index !== IW'(k % NF)) begin
          fails++;
          $display("FAIL %s index[%0d]: got %0d, required %0d",
                   name, k, bin_index, k % NF);
        end
        checks++;
        if (bin_last !== (k % NF == NF - 1)) begin
          fails++;
          $display("FAIL %s last[%0d]: got %b, required %b",
                   name, k, bin_last, (k % NF == NF - 1));
        end
        checks++;
        if (frame_peak_value !== DW'(epk[k / NF]) ||
            frame_peak_index !== IW'(epi[k / NF])) begin
          fails++;
          $display("FAIL %s peak[%0d]: got %0d@%0d, required %0d@%0d",
                   name, k, $signed(frame_peak_value),
                   frame_peak_index, epk[k / NF], epi[k / NF]);
        end
        k++;
      end else if (bin_valid) begin
        held = 1'b1;
        hv = bin_out;
        hi = bin_index;
        hl = bin_last;
      end
      tick();
      budget--;
    end
    checks++;
    if (k != ev.size()) begin
      fails++;
      $display("FAIL %s timeout: got %0d bins, required %0d",
               name, k, ev.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (bin_valid !== 1'b0 || bin_last !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: valid=%b last=%b, required 0 0",
               bin_valid, bin_last);
    end
    checks++;
    if (bin_out !== '0 || bin_index !== '0) begin
      fails++;
      $display("FAIL reset_bin: out=%0d idx=%0d, required 0 0",
               bin_out, bin_index);
    end
    checks++;
    if (frame_peak_value !== '0 || frame_peak_index !== '0 ||
        overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_peak: pk=%0d@%0d ovf=%b, required 0@0 0",
               frame_peak_value, frame_peak_index, overflow);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    bin_ready = 1'b0;
    wq.delete();
    for (int i = 0; i < NF; i++) wq.push_back(i * i);
    ev = wq;
    epk = '{49};
    epi = '{7};
    write_seq();
    checks++;
    if (bin_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_lat0: valid=%b, required 0", bin_valid);
    end
    tick();
    checks++;
    if (bin_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_lat1: valid=%b, required 0", bin_valid);
    end
    tick();
    checks++;
    if (bin_valid !== 1'b1 || bin_index !== '0) begin
      fails++;
      $display("FAIL single_lat2: valid=%b idx=%0d, required 1 0",
               bin_valid, bin_index);
    end
    read_expect("single", 1'b0);
  endtask

  task automatic test_back_pressure();
    bin_ready = 1'b0;
    wq.delete();
    for (int i = 0; i < NF; i++) wq.push_back(i * i);
    ev = wq;
    epk = '{49};
    epi = '{7};
    write_seq();
    read_expect("backpressure", 1'b1);
  endtask

  task automatic test_ping_pong();
    bin_ready = 1'b0;
    wq.delete();
    ev.delete();
    for (int f = 1; f <= 3; f++) begin
      if (f == 3) wq.push_back(GAP);
      for (int i = 0; i < NF; i++) begin
        wq.push_back(10 * f + i);
        ev.push_back(10 * f + i);
      end
    end
    epk = '{17, 27, 37};
    epi = '{7, 7, 7};
    fork
      write_seq();
      read_expect("pingpong", 1'b0);
    join
    checks++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL pingpong_ovf: got %b, required 0", overflow);
    end
  endtask

  task automatic test_peak_tie();
    bin_ready = 1'b0;
    wq = '{5, 9, 3, 9, 0, 9, 1, 2,
           -5, -2, -9, -2, -7, -3, -8, -4};
    ev = wq;
    epk = '{9, -2};
    epi = '{1, 1};
    write_seq();
    read_expect("peaktie", 1'b0);
  endtask

  task automatic test_overflow();
    bin_ready = 1'b0;
    wq.delete();
    ev.delete();
    for (int i = 0; i < NF; i++) wq.push_back(100 + i);
    for (int i = 0; i < NF; i++) wq.push_back(200 + i);
    ev = wq;
    write_seq();
    checks++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_early: got %b, required 0", overflow);
    end
    wq.delete();
    for (int i = 0; i < NF; i++) wq.push_back(300 + i);
    write_seq();
    checks++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set: got %b, required 1", overflow);
    end
    checks++;
    if (bin_valid !== 1'b1 || bin_index !== '0 ||
        bin_out !== DW'(100)) begin
      fails++;
      $display("FAIL ovf_stall: v=%b idx=%0d out=%0d, required 1 0 100",
               bin_valid, bin_index, bin_out);
    end
    epk = '{107, 207};
    epi = '{7, 7};
    read_expect("overflow", 1'b0);
    repeat (6) tick();
    checks++;
    if (bin_valid !== 1'b0) begin
      fails++;
      $display("FAIL ovf_dropped: valid=%b, required 0", bin_valid);
    end
    checks++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_sticky: got %b, required 1", overflow);
    end
  endtask

  task automatic test_reset_mid();
    bin_ready = 1'b1;
    wq.delete();
    for (int i = 0; i < NF; i++) wq.push_back(50 + i);
    wq.push_back(GAP);
    for (int i = 0; i < NF; i++) wq.push_back(60 + i);
    fork
      write_seq();
      begin
        int budget;
        budget = 40;
        while (!(bin_valid === 1'b1 && bin_index === IW'(3)) &&
               budget > 0) begin
          tick();
          budget--;
        end
        checks++;
        if (budget == 0) begin
          fails++;
          $display("FAIL rstmid_reach: idx=%0d, required 3", bin_index);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bin_valid !== 1'b0 || bin_last !== 1'b0 ||
            bin_out !== '0 || bin_index !== '0) begin
          fails++;
          $display("FAIL rstmid_bin: v=%b l=%b out=%0d idx=%0d, required 0",
                   bin_valid, bin_last, bin_out, bin_index);
        end
        checks++;
        if (frame_peak_value !== '0 || frame_peak_index !== '0 ||
            overflow !== 1'b0) begin
          fails++;
          $display("FAIL rstmid_peak: pk=%0d@%0d ovf=%b, required 0",
                   frame_peak_value, frame_peak_index, overflow);
        end
      end
    join
    tick();
    rst = 1'b0;
    bin_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (bin_valid !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_idle: v=%b ovf=%b, required 0 0",
               bin_valid, overflow);
    end
    wq.delete();
    for (int i = 0; i < NF; i++) wq.push_back(70 + i);
    ev = wq;
    epk = '{77};
    epi = '{7};
    write_seq();
    read_expect("rstmid_fresh", 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    fails = 0;
    rst = 1'b1;
    periodogram_in = '0;
    periodogram_valid = 1'b0;
    bin_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_back_pressure();
    test_ping_pong();
    test_peak_tie();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
